approx_mult_err_monitor: RTL



---
 rtl/approx_mult_pkg.sv | 30 +++
 rtl/err_dist_unit.sv | 59 +++++
 rtl/approx_mult_err_monitor.sv | 118 +++++++++++
 3 files changed

// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared definitions for the approximate-multiplier error monitor
// Purpose: default operand/product widths, FSM state encoding and the
// saturating-add helper used by the statistics accumulators.
// Ports: none (package).
package approx_mult_pkg;

   localparam int W_DEF  = 8;
   localparam int RW_DEF = 2 * W_DEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Callers zero-extend their operands to 64 bits and truncate the result
   // back to their own width; width must stay below 63 so acc + inc never
   // overflows the 64-bit intermediate.
   function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                           input logic [63:0] inc,
                                           input int          width);
      logic [63:0] lim;
      logic [63:0] sum;
      lim = (64'd1 << width) - 64'd1;
      sum = acc + inc;
      return (sum > lim) ? lim : sum;
   endfunction

endpackage

// File: rtl/err_dist_unit.sv
// rtl/err_dist_unit.sv - two-stage exact-product and error-distance pipeline
// Purpose: S1 registers the exact product and the approximate product on
// accept; S2 registers the absolute error distance. One sample per cycle.
// Ports:
//   clk, rst        clock and synchronous active-high reset (flushes stages)
//   accept          a sample is taken this cycle
//   a, b            operands
//   r_approx        approximate product under test
//   ed, ed_valid    registered |exact - r_approx| and its valid flag
//   s1_valid        S1 occupancy, used by the caller to detect drain
module err_dist_unit
   import approx_mult_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int RW = 2 * W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          accept,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic [RW-1:0] r_approx,
   output logic [RW-1:0] ed,
   output logic          ed_valid,
   output logic          s1_valid
);

   logic [RW-1:0] exact;
   logic [RW-1:0] approx_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         exact    <= '0;
         approx_q <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            exact    <= RW'(a) * RW'(b);
            approx_q <= r_approx;
         end
      end
   end

   // Compare first, then subtract the smaller from the larger so the
   // distance never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         ed_valid <= 1'b0;
         ed       <= '0;
      end else begin
         ed_valid <= s1_valid;
         if (s1_valid) begin
            ed <= (exact >= approx_q) ? (exact - approx_q) : (approx_q - exact);
         end
      end
   end

endmodule

// File: rtl/approx_mult_err_monitor.sv
// rtl/approx_mult_err_monitor.sv - streaming error-metric accumulator for approximate multipliers
// Purpose: accepts (a, b, r_approx) samples during a run, and accumulates
// the sum and maximum of error distances, the erroneous-sample count and
// the total sample count. Statistics hold after the run until next start.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start                    pulse: clear statistics and begin a run
//   in_valid/in_ready        sample handshake; in_last marks the final sample
//   a, b, r_approx           operands and approximate product
//   busy, done               run in progress / statistics stable
//   sum_ed, max_ed           saturating sum and maximum of error distances
//   err_cnt, sample_cnt      saturating erroneous and total sample counts
module approx_mult_err_monitor
   import approx_mult_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int SUM_W = 32,
   parameter int CNT_W = 17,
   localparam int RW   = 2 * W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [RW-1:0]    r_approx,
   output logic             busy,
   output logic             done,
   output logic [SUM_W-1:0] sum_ed,
   output logic [RW-1:0]    max_ed,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] sample_cnt
);

   state_t        state;
   logic          accept;
   logic          start_ok;
   logic [RW-1:0] ed;
   logic          ed_valid;
   logic          s1_valid;

   assign accept   = in_valid && in_ready;
   assign start_ok = start && ((state == IDLE) || (state == DONE));

   err_dist_unit #(.W(W), .RW(RW)) u_edu (
      .clk      (clk),
      .rst      (rst),
      .accept   (accept),
      .a        (a),
      .b        (b),
      .r_approx (r_approx),
      .ed       (ed),
      .ed_valid (ed_valid),
      .s1_valid (s1_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= RUN;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end
            end
            RUN: begin
               if (accept && in_last) begin
                  state    <= DRAIN;
                  in_ready <= 1'b0;
               end
            end
            DRAIN: begin
               // With S1 empty, only S2 may still hold a sample and it is
               // folded into the statistics on this same edge, so both stages
               // are empty once DONE is entered.
               if (!s1_valid) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         sum_ed     <= '0;
         max_ed     <= '0;
         err_cnt    <= '0;
         sample_cnt <= '0;
      end else if (ed_valid) begin
         sum_ed     <= SUM_W'(sat_add(64'(sum_ed), 64'(ed), SUM_W));
         err_cnt    <= CNT_W'(sat_add(64'(err_cnt), {63'd0, (ed != '0)}, CNT_W));
         sample_cnt <= CNT_W'(sat_add(64'(sample_cnt), 64'd1, CNT_W));
         if (ed > max_ed) begin
            max_ed <= ed;
         end
      end
   end

endmodule
